// File: rtl/mac_result_requant.sv
// Requantizes signed 32-bit MAC results (round-half-up shift, signed saturation)
// and packs them little-endian into 32-bit words for TCDM write-back.
module mac_result_requant #(
  parameter int OUT_W = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             start_i,
  input  logic [CNT_W-1:0] len_i,
  input  logic [4:0]       shift_i,
  input  logic             d_valid_i,
  input  logic [31:0]      d_data_i,
  output logic             d_ready_o,
  output logic             out_valid_o,
  output logic [31:0]      out_data_o,
  output logic [3:0]       out_strb_o,
  input  logic             out_ready_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [CNT_W-1:0] sat_cnt_o
);
  localparam int PACK   = 32 / OUT_W;
  localparam int LANE_W = $clog2(PACK + 1);
  localparam int BPL    = OUT_W / 8;
  localparam logic signed [32:0] MAX_V = 33'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
  localparam logic signed [32:0] MIN_V = -MAX_V - 33'sd1;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  len_q, len_d, elem_q, elem_d, sat_q, sat_d;
  logic [4:0]        shift_q, shift_d;
  logic [LANE_W-1:0] lane_q, lane_d;
  logic [31:0]       stage_q, stage_d;
  logic              full_q, full_d;
  logic              out_valid_q, out_valid_d;
  logic [31:0]       out_data_q, out_data_d;
  logic [3:0]        out_strb_q, out_strb_d;
  logic              done_q, done_d;

  logic signed [32:0] round_t, shifted;
  logic [OUT_W-1:0]   req_val;
  logic               req_sat;
  logic [31:0]        word_w;
  logic [LANE_W-1:0]  lane_inc;
  logic [CNT_W-1:0]   elem_inc;
  logic               out_free, acc, word_done;

  // Rounding bias is added before the shift on a 33-bit value so it cannot overflow.
  always_comb begin
    round_t = $signed({d_data_i[31], d_data_i})
            + ((shift_q != 5'd0) ? (33'sd1 <<< (shift_q - 5'd1)) : 33'sd0);
    shifted = round_t >>> shift_q;
    req_sat = (shifted > MAX_V) || (shifted < MIN_V);
    if (shifted > MAX_V)      req_val = MAX_V[OUT_W-1:0];
    else if (shifted < MIN_V) req_val = MIN_V[OUT_W-1:0];
    else                      req_val = shifted[OUT_W-1:0];
  end

  for (genvar gi = 0; gi < PACK; gi++) begin : g_lane
    assign word_w[gi*OUT_W +: OUT_W] = (lane_q == LANE_W'(gi)) ? req_val
                                                               : stage_q[gi*OUT_W +: OUT_W];
  end

  function automatic logic [3:0] strb_of(input logic [LANE_W-1:0] n);
    logic [3:0] s;
    s = '0;
    for (int b = 0; b < 4; b++) begin
      if ((b / BPL) < int'(n)) s[b] = 1'b1;
    end
    return s;
  endfunction

  assign d_ready_o = (state_q == RUN) && !full_q;

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    shift_d     = shift_q;
    elem_d      = elem_q;
    sat_d       = sat_q;
    lane_d      = lane_q;
    stage_d     = stage_q;
    full_d      = full_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_strb_d  = out_strb_q;
    done_d      = 1'b0;
    out_free    = !out_valid_q || out_ready_i;
    lane_inc    = lane_q + LANE_W'(1);
    elem_inc    = elem_q + CNT_W'(1);
    acc         = d_valid_i && d_ready_o;
    word_done   = (lane_inc == LANE_W'(PACK)) || (elem_inc == len_q);

    if (out_valid_q && out_ready_i) out_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          len_d   = len_i;
          shift_d = shift_i;
          sat_d   = '0;
          elem_d  = '0;
          lane_d  = '0;
          stage_d = '0;
          full_d  = 1'b0;
          state_d = (len_i == '0) ? FLUSH : RUN;
        end
      end
      RUN: begin
        if (full_q) begin
          if (out_free) begin
            out_valid_d = 1'b1;
            out_data_d  = stage_q;
            out_strb_d  = strb_of(lane_q);
            stage_d     = '0;
            lane_d      = '0;
            full_d      = 1'b0;
            if (elem_q == len_q) state_d = FLUSH;
          end
        end else if (acc) begin
          elem_d = elem_inc;
          if (req_sat && !(&sat_q)) sat_d = sat_q + CNT_W'(1);
          // A completing element bypasses staging when the output register is free.
          if (word_done && out_free) begin
            out_valid_d = 1'b1;
            out_data_d  = word_w;
            out_strb_d  = strb_of(lane_inc);
            stage_d     = '0;
            lane_d      = '0;
            if (elem_inc == len_q) state_d = FLUSH;
          end else begin
            stage_d = word_w;
            lane_d  = lane_inc;
            full_d  = word_done;
          end
        end
      end
      FLUSH: begin
        if (out_free) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (clear_i) begin
      state_d     = IDLE;
      len_d       = '0;
      shift_d     = '0;
      elem_d      = '0;
      sat_d       = '0;
      lane_d      = '0;
      stage_d     = '0;
      full_d      = 1'b0;
      out_valid_d = 1'b0;
      out_data_d  = '0;
      out_strb_d  = '0;
      done_d      = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      len_q       <= '0;
      shift_q     <= '0;
      elem_q      <= '0;
      sat_q       <= '0;
      lane_q      <= '0;
      stage_q     <= '0;
      full_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_strb_q  <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      shift_q     <= shift_d;
      elem_q      <= elem_d;
      sat_q       <= sat_d;
      lane_q      <= lane_d;
      stage_q     <= stage_d;
      full_q      <= full_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_strb_q  <= out_strb_d;
      done_q      <= done_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_strb_o  = out_strb_q;
  assign busy_o      = (state_q != IDLE);
  assign done_o      = done_q;
  assign sat_cnt_o   = sat_q;

endmodule

// File: tb/tb_mac_result_requant.sv
// Bench for mac_result_requant: directed and random jobs checked against an
// arithmetic requantize/pack model; a second 16-bit instance covers rounding.
module tb_mac_result_requant;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, clear, start, d_valid, d_ready, o_valid, o_ready, busy, done;
  logic [15:0] len, sat_cnt;
  logic [4:0]  shift;
  logic [31:0] d_data, o_data;
  logic [3:0]  o_strb;

  logic        w_start, w_dvalid, w_dready, w_ovalid, w_oready, w_busy, w_done;
  logic [15:0] w_len, w_sat;
  logic [4:0]  w_shift;
  logic [31:0] w_ddata, w_odata;
  logic [3:0]  w_ostrb;

  int tests = 0;
  int fails = 0;
  int in_q[$];

  mac_result_requant #(.OUT_W(8), .CNT_W(16)) dut (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .start_i(start), .len_i(len),
    .shift_i(shift), .d_valid_i(d_valid), .d_data_i(d_data), .d_ready_o(d_ready),
    .out_valid_o(o_valid), .out_data_o(o_data), .out_strb_o(o_strb),
    .out_ready_i(o_ready), .busy_o(busy), .done_o(done), .sat_cnt_o(sat_cnt)
  );

  mac_result_requant #(.OUT_W(16), .CNT_W(16)) dut16 (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .start_i(w_start), .len_i(w_len),
    .shift_i(w_shift), .d_valid_i(w_dvalid), .d_data_i(w_ddata), .d_ready_o(w_dready),
    .out_valid_o(w_ovalid), .out_data_o(w_odata), .out_strb_o(w_ostrb),
    .out_ready_i(w_oready), .busy_o(w_busy), .done_o(w_done), .sat_cnt_o(w_sat)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Round-half-up division by 2^sh (floor of (x + half) / 2^sh), then clamp.
  function automatic int model_rq(input int x, input int sh, input int ow, output bit sat);
    longint t, d, q, mx;
    d = longint'(1) << sh;
    t = longint'(x) + ((sh > 0) ? d / 2 : longint'(0));
    q = t / d;
    if ((t % d) != 0 && t < 0) q = q - 1;
    mx = (longint'(1) << (ow - 1)) - 1;
    sat = 1'b0;
    if (q > mx) begin
      q = mx;
      sat = 1'b1;
    end else if (q < -mx - 1) begin
      q = -mx - 1;
      sat = 1'b1;
    end
    return int'(q);
  endfunction

  task automatic run_job(input int n, input int sh, input bit bp);
    logic [31:0] exp_w[$];
    logic [3:0]  exp_st[$];
    logic [31:0] w, held_d;
    logic [3:0]  st;
    int exp_sat, idx, v;
    bit s, acc, got_done, held_v;
    exp_sat = 0;
    for (int i = 0; i < n; i += 4) begin
      w = '0;
      st = '0;
      for (int k = 0; k < 4 && i + k < n; k++) begin
        v = model_rq(in_q[i+k], sh, 8, s);
        if (s) exp_sat++;
        w[k*8 +: 8] = v[7:0];
        st[k] = 1'b1;
      end
      exp_w.push_back(w);
      exp_st.push_back(st);
    end
    @(negedge clk);
    start = 1'b1; len = n[15:0]; shift = sh[4:0];
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", 32'(busy), 32'd1);
    idx = 0; acc = 0; got_done = 0; held_v = 0; held_d = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (acc) idx++;
      if (done) begin
        got_done = 1;
        break;
      end
      if (held_v) begin
        chk("no_retract", 32'(o_valid), 32'd1);
        chk("stable_data", o_data, held_d);
      end
      d_valid = (idx < n) && (bp || $urandom_range(0, 3) != 0);
      d_data  = d_valid ? in_q[idx] : $urandom;
      acc     = d_valid && d_ready;
      if (bp) o_ready = !(cyc >= 8 && cyc < 18);
      else    o_ready = ($urandom_range(0, 2) != 0);
      if (bp && cyc == 17) chk("bp_dready_low", 32'(d_ready), 32'd0);
      start = (cyc == 3 && busy);
      len   = (cyc == 3) ? 16'd1 : len;
      if (o_valid && o_ready) begin
        if (exp_w.size() == 0) chk("extra_word", 32'(o_valid), 32'd0);
        else begin
          chk("word", o_data, exp_w.pop_front());
          chk("strb", 32'(o_strb), 32'(exp_st.pop_front()));
        end
      end
      held_v = o_valid && !o_ready;
      held_d = o_data;
      @(negedge clk);
    end
    start = 1'b0;
    d_valid = 1'b0;
    chk("done_seen", 32'(got_done), 32'd1);
    chk("words_left", exp_w.size(), 32'd0);
    chk("elems_sent", idx, n);
    chk("sat_cnt", 32'(sat_cnt), exp_sat);
    chk("idle_at_done", 32'(busy), 32'd0);
    @(negedge clk);
    chk("done_pulse", 32'(done), 32'd0);
    $display("[TB] job len=%0d shift=%0d bp=%0d checked", n, sh, bp);
  endtask

  initial begin
    logic [31:0] w16;
    bit s;
    int v0, v1;
    rst_n = 0; clear = 0; start = 0; len = 0; shift = 0; d_valid = 0; d_data = 0; o_ready = 1;
    w_start = 0; w_len = 0; w_shift = 0; w_dvalid = 0; w_ddata = 0; w_oready = 1;
    repeat (2) @(negedge clk);
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(d_ready), 32'd0);
    chk("rst_sat", 32'(sat_cnt), 32'd0);
    rst_n = 1;

    in_q = '{32'sh10, 32'sh18, 32'sh7FFF, -32'sh7FFF};
    run_job(4, 4, 0);
    in_q = '{1, 2, 3, 4, 5, 6};
    run_job(6, 0, 0);

    // 16-bit lanes: 3 and -3 with shift 1 round to 2 and -1.
    @(negedge clk); w_start = 1; w_len = 16'd2; w_shift = 5'd1;
    @(negedge clk); w_start = 0;
    chk("w16_ready", 32'(w_dready), 32'd1);
    w_dvalid = 1; w_ddata = 32'd3;
    @(negedge clk); w_ddata = -32'sd3;
    @(negedge clk); w_dvalid = 0;
    v0 = model_rq(3, 1, 16, s);
    v1 = model_rq(-3, 1, 16, s);
    w16 = {v1[15:0], v0[15:0]};
    chk("w16_valid", 32'(w_ovalid), 32'd1);
    chk("w16_data", w_odata, w16);
    chk("w16_strb", 32'(w_ostrb), 32'hF);
    @(negedge clk);
    chk("w16_done", 32'(w_done), 32'd1);
    $display("[TB] 16-bit rounding job checked");

    // Backpressure over 64 random elements.
    in_q.delete();
    for (int i = 0; i < 64; i++) in_q.push_back(int'($urandom) >>> $urandom_range(0, 20));
    run_job(64, $urandom_range(0, 31), 1);
    in_q.delete();
    for (int i = 0; i < 13; i++) in_q.push_back(int'($urandom) >>> $urandom_range(0, 24));
    run_job(13, $urandom_range(0, 12), 0);

    // Empty job.
    @(negedge clk); start = 1; len = 0;
    @(negedge clk); start = 0;
    chk("len0_busy", 32'(busy), 32'd1);
    chk("len0_done_early", 32'(done), 32'd0);
    @(negedge clk);
    chk("len0_done", 32'(done), 32'd1);
    chk("len0_novalid", 32'(o_valid), 32'd0);
    @(negedge clk);
    chk("len0_done_pulse", 32'(done), 32'd0);
    $display("[TB] len=0 job checked");

    // Async reset with a partial, saturated word in staging.
    @(negedge clk); start = 1; len = 16'd8; shift = 5'd0;
    @(negedge clk); start = 0; d_valid = 1; d_data = 32'h7FFF_FFFF;
    @(negedge clk);
    @(negedge clk); d_valid = 0;
    chk("pre_rst_sat", 32'(sat_cnt), 32'd2);
    rst_n = 0;
    #1;
    chk("arst_sat", 32'(sat_cnt), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_valid", 32'(o_valid), 32'd0);
    chk("arst_data", o_data, 32'd0);
    chk("arst_strb", 32'(o_strb), 32'd0);
    chk("arst_ready", 32'(d_ready), 32'd0);
    @(negedge clk); rst_n = 1;
    in_q.delete();
    for (int i = 0; i < 9; i++) in_q.push_back(int'($urandom) >>> $urandom_range(0, 16));
    run_job(9, 3, 0);

    // Synchronous clear mid-job.
    @(negedge clk); start = 1; len = 16'd5;
    @(negedge clk); start = 0; d_valid = 1; d_data = 32'h8000_0000;
    @(negedge clk); d_valid = 0; clear = 1;
    @(negedge clk); clear = 0;
    chk("clr_busy", 32'(busy), 32'd0);
    chk("clr_sat", 32'(sat_cnt), 32'd0);
    chk("clr_done", 32'(done), 32'd0);
    $display("[TB] reset/clear abort checked");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
